rvfi_retire_tracker: RTL
========================

// Module: rvfi_retire_tracker
//
// PURPOSE
//   Multi-lane RVFI retirement tracker for the SoC gate-level/RTL benches. Sits beside the
//   riscv-formal monitor on the DUT's NRET-wide commit bus. It checks lane packing and
//   commit-order continuity, detects halt, measures start/stop-marker segment IPC in
//   hardware counters, and counts software mismatch/warning markers. All results are
//   registered outputs, so the bench and formal harnesses can consume them without $display.
//
// PARAMETERS
//   NRET    2   retire lanes per cycle (1..4); lane 0 is oldest
//   CNT_W   40  width of segment instruction/cycle counters (saturating)
//   ORD_W   64  width of rvfi order field
//
// PORTS
//   clk            in   1          clock
//   rst            in   1          synchronous active-high reset
//   valid          in   NRET       per-lane commit valid
//   order          in   NRET*ORD_W per-lane order; lane i at [i*ORD_W +: ORD_W]
//   inst           in   NRET*32    per-lane instruction word
//   pc_rdata       in   NRET*32    per-lane PC of the committed instruction
//   pc_wdata       in   NRET*32    per-lane next PC
//   halt           out  1          sticky; program reached a halt condition
//   error          out  1          sticky; any check failed
//   err_code       out  3          code of the first error; 0 = none
//   seg_active     out  1          segment measurement in progress
//   seg_done       out  1          one-cycle pulse when a segment closes
//   seg_inst_cnt   out  CNT_W      instructions retired in the segment
//   seg_cycle_cnt  out  CNT_W      cycles elapsed in the segment
//   mismatch_cnt   out  16         count of FF602013 markers (saturating)
//   warn_cnt       out  16         count of FF502013 markers (saturating)
//
// BEHAVIOUR
//   Reset: all outputs 0. exp_order = 0. Every output is registered (1-cycle latency).
//   Lane packing: valid must be thermometer (valid[i] => valid[i-1]). Violation -> code 1 PACK.
//   Order: active lane i must carry order == exp_order + i, else code 2 ORDER.
//     exp_order += popcount(valid) every cycle, including error cycles. Wraps mod 2^ORD_W.
//   Halt: set when any valid lane has pc_rdata == pc_wdata, or inst is 00000063, 0000006F or
//     F0002013. halt rises the cycle after that commit and is cleared only by rst.
//   Post-halt commit: any valid lane while halt==1 -> code 3 POST_HALT.
//     Lanes in the same cycle after the halting lane are legal.
//   Markers are recognised only on valid lanes:
//     00102013 START
//     00202013 STOP
//     FF602013 MISMATCH: mismatch_cnt++ and code 4 SW_MISMATCH
//     FF502013 WARN: warn_cnt++
//     Several MISMATCH/WARN lanes in one cycle each increment their counter.
//   Segment rules (only the lowest-lane START/STOP in a cycle acts; later ones are ignored):
//     START at lane s: counters load inst = number of valid lanes above s, cycle = 0.
//       seg_active <= 1. A START while already active restarts the segment.
//     STOP at lane p with seg_active: inst += number of valid lanes at or below p; cycle += 1.
//       seg_active <= 0 and seg_done pulses. Counters then hold until the next START.
//     STOP with seg_active==0: ignored.
//     Otherwise while active: inst += popcount(valid), cycle += 1.
//     All counters saturate at all-ones; there is no wrap.
//   X on valid (simulation only, $isunknown): code 5 X_VALID. The cycle is treated as valid=0.
//   Error capture: error and err_code latch the first failing cycle. If several checks fail in
//     the same cycle, the lowest code wins. Later errors never overwrite err_code.
//   rst mid-segment or mid-halt: returns everything to reset values on the next edge.
//
// TESTING
//   1. NRET=2: commit orders 0,1 | 2,3 | 4 (lane0 only) -> error stays 0, exp_order reaches 5.
//   2. valid=2'b10 with order 0 -> next cycle error=1, err_code=1 (PACK wins over ORDER).
//   3. Orders 0,1 then 3,4 -> err_code=2. A later PACK violation leaves err_code at 2.
//   4. START lane1 in cycle 0, 2 valid lanes/cycle for 9 cycles, STOP lane0 in cycle 10
//      -> seg_done pulse, seg_inst_cnt=19, seg_cycle_cnt=10, seg_active=0.
//   5. Lane0 inst 0000006F with lane1 valid -> halt=1 next cycle, no error.
//      Next valid commit -> err_code=3.
//   6. Lanes FF602013 and FF502013 in one cycle, then rst asserted mid-segment
//      -> mismatch_cnt=1, warn_cnt=1, err_code=4; after rst all outputs are 0.

Source files
------------

// File: rtl/rvfi_retire_tracker.sv
// rvfi_retire_tracker
//   Watches an NRET-wide RVFI commit bus. It checks that the valid lanes are
//   packed, that the order fields are continuous, detects halt, measures
//   START/STOP segment IPC and counts software MISMATCH/WARN markers.
//   Every output is registered.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   valid           per-lane commit valid (lane 0 oldest)
//   order           per-lane rvfi order, lane i at [i*ORD_W +: ORD_W]
//   inst            per-lane instruction word
//   pc_rdata        per-lane PC of the committed instruction
//   pc_wdata        per-lane next PC
//   halt            sticky halt seen
//   error, err_code sticky error flag and code of the first error
//                   (1 PACK, 2 ORDER, 3 POST_HALT, 4 SW_MISMATCH, 5 X_VALID)
//   seg_active      segment measurement running
//   seg_done        one-cycle pulse when a segment closes
//   seg_inst_cnt    instructions retired in the segment (saturating)
//   seg_cycle_cnt   cycles elapsed in the segment (saturating)
//   mismatch_cnt    FF602013 markers seen (saturating)
//   warn_cnt        FF502013 markers seen (saturating)
module rvfi_retire_tracker #(
    parameter int NRET  = 2,
    parameter int CNT_W = 40,
    parameter int ORD_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRET-1:0]       valid,
    input  logic [NRET*ORD_W-1:0] order,
    input  logic [NRET*32-1:0]    inst,
    input  logic [NRET*32-1:0]    pc_rdata,
    input  logic [NRET*32-1:0]    pc_wdata,
    output logic                  halt,
    output logic                  error,
    output logic [2:0]            err_code,
    output logic                  seg_active,
    output logic                  seg_done,
    output logic [CNT_W-1:0]      seg_inst_cnt,
    output logic [CNT_W-1:0]      seg_cycle_cnt,
    output logic [15:0]           mismatch_cnt,
    output logic [15:0]           warn_cnt
);

    localparam logic [31:0] INST_BEQ_SELF = 32'h0000_0063;
    localparam logic [31:0] INST_JAL_SELF = 32'h0000_006F;
    localparam logic [31:0] INST_HALT_MRK = 32'hF000_2013;
    localparam logic [31:0] INST_START    = 32'h0010_2013;
    localparam logic [31:0] INST_STOP     = 32'h0020_2013;
    localparam logic [31:0] INST_MISMATCH = 32'hFF60_2013;
    localparam logic [31:0] INST_WARN     = 32'hFF50_2013;

    logic [ORD_W-1:0] exp_order;

    logic            x_valid;
    logic [NRET-1:0] v;
    logic            pack_err;
    logic            order_err;
    logic            halt_hit;
    logic [2:0]      n_valid;
    logic [2:0]      n_mis;
    logic [2:0]      n_warn;
    logic            mark_found;
    logic            mark_is_start;
    logic [2:0]      mark_lane;
    logic [2:0]      n_above;
    logic [2:0]      n_at_below;
    logic [31:0]     inst_i;
    logic [2:0]      new_code;

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] a, input logic [2:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-2){1'b0}}, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    function automatic logic [15:0] sat16(input logic [15:0] a, input logic [2:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {14'd0, b};
        return s[16] ? '1 : s[15:0];
    endfunction

    always_comb begin
        // An unknown valid vector is flagged and the cycle is treated as idle.
        x_valid       = $isunknown(valid);
        v             = x_valid ? '0 : valid;
        pack_err      = 1'b0;
        order_err     = 1'b0;
        halt_hit      = 1'b0;
        n_valid       = '0;
        n_mis         = '0;
        n_warn        = '0;
        mark_found    = 1'b0;
        mark_is_start = 1'b0;
        mark_lane     = '0;
        n_above       = '0;
        n_at_below    = '0;
        inst_i        = '0;

        for (int i = 1; i < NRET; i++) begin
            if (v[i] && !v[i-1]) pack_err = 1'b1;
        end

        for (int i = 0; i < NRET; i++) begin
            if (v[i]) begin
                inst_i  = inst[i*32 +: 32];
                n_valid = n_valid + 3'd1;
                if (order[i*ORD_W +: ORD_W] != exp_order + ORD_W'(i)) order_err = 1'b1;
                if (pc_rdata[i*32 +: 32] == pc_wdata[i*32 +: 32] ||
                    inst_i == INST_BEQ_SELF || inst_i == INST_JAL_SELF ||
                    inst_i == INST_HALT_MRK)
                    halt_hit = 1'b1;
                if (inst_i == INST_MISMATCH) n_mis = n_mis + 3'd1;
                if (inst_i == INST_WARN) n_warn = n_warn + 3'd1;
                // Only the oldest START/STOP in a cycle is acted on.
                if (!mark_found && (inst_i == INST_START || inst_i == INST_STOP)) begin
                    mark_found    = 1'b1;
                    mark_is_start = (inst_i == INST_START);
                    mark_lane     = 3'(i);
                end
            end
        end

        for (int i = 0; i < NRET; i++) begin
            if (v[i] && 3'(i) > mark_lane)  n_above    = n_above + 3'd1;
            if (v[i] && 3'(i) <= mark_lane) n_at_below = n_at_below + 3'd1;
        end

        // Lowest code wins when several checks fail together.
        if (pack_err)              new_code = 3'd1;
        else if (order_err)        new_code = 3'd2;
        else if (halt && (|v))     new_code = 3'd3;
        else if (n_mis != 3'd0)    new_code = 3'd4;
        else if (x_valid)          new_code = 3'd5;
        else                       new_code = 3'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_order     <= '0;
            halt          <= 1'b0;
            error         <= 1'b0;
            err_code      <= '0;
            seg_active    <= 1'b0;
            seg_done      <= 1'b0;
            seg_inst_cnt  <= '0;
            seg_cycle_cnt <= '0;
            mismatch_cnt  <= '0;
            warn_cnt      <= '0;
        end else begin
            exp_order    <= exp_order + ORD_W'(n_valid);
            halt         <= halt | halt_hit;
            mismatch_cnt <= sat16(mismatch_cnt, n_mis);
            warn_cnt     <= sat16(warn_cnt, n_warn);
            seg_done     <= 1'b0;

            if (!error && new_code != 3'd0) begin
                error    <= 1'b1;
                err_code <= new_code;
            end

            if (mark_found && mark_is_start) begin
                // Instructions younger than START belong to the new segment.
                seg_active    <= 1'b1;
                seg_inst_cnt  <= CNT_W'(n_above);
                seg_cycle_cnt <= '0;
            end else if (mark_found && seg_active) begin
                // STOP and everything older than it close out the segment.
                seg_active    <= 1'b0;
                seg_done      <= 1'b1;
                seg_inst_cnt  <= sat_cnt(seg_inst_cnt, n_at_below);
                seg_cycle_cnt <= sat_cnt(seg_cycle_cnt, 3'd1);
            end else if (seg_active) begin
                seg_inst_cnt  <= sat_cnt(seg_inst_cnt, n_valid);
                seg_cycle_cnt <= sat_cnt(seg_cycle_cnt, 3'd1);
            end
        end
    end

endmodule
